fifo_rd_stream: RTL
===================

Name: fifo_rd_stream

Overview:
- Read-side drain stage that sits directly downstream of the asynchronous FIFO, entirely in the clk_out domain.
- Issues remove pulses against the FIFO's empty flag and captures data_out one cycle later.
- Presents the words on a valid/ready stream through a 2-entry skid buffer, at full throughput (one word per cycle).
- Also counts delivered words and honours a synchronous flush.

Parameters:
- WIDTH, 32: data word width; matches the FIFO word width.
- CNT_W, 16: width of the delivered-word counter.

Ports:
- clk_out  input  1  read-domain clock; the only clock of the block.
- reset  input  1  asynchronous, active-low reset.
- fifo_data  input  WIDTH  FIFO data_out; valid exactly 1 cycle after a remove accepted while fifo_empty=0.
- fifo_empty  input  1  FIFO empty flag, clk_out domain.
- fifo_remove  output  1  remove request to the FIFO.
- flush  input  1  synchronous drop of all buffered and in-flight words.
- m_data  output  WIDTH  stream data, always the oldest buffered word.
- m_valid  output  1  stream valid.
- m_ready  input  1  downstream ready.
- xfer_count  output  CNT_W  number of words delivered (m_valid && m_ready), modulo 2^CNT_W.

Behaviour:
- Reset (reset=0, asynchronous) values:
  - fifo_remove=0, m_valid=0, m_data=0, xfer_count=0.
  - Occupancy=0, in-flight flag=0, drop flag=0.
- Definitions:
  - pop = m_valid && m_ready.
  - inflight = registered copy of (fifo_remove && !fifo_empty) from the previous cycle.
- Occupancy FSM: states EMPTY(0), ONE(1), TWO(2). Per-cycle update: occ_next = occ + (inflight && !drop) - pop.
  - EMPTY -> ONE: a word arrives with no pop.
  - ONE -> TWO: a word arrives with no pop.
  - ONE -> EMPTY: pop with no arrival.
  - TWO -> ONE: pop with no arrival.
  - Arrival and pop in the same cycle: no state change.
  - occ_next > 2 cannot occur. A bench assertion must flag it.
- Remove rule (combinational): fifo_remove = !fifo_empty && !flush && (occ + inflight - pop) < 2.
  - This sustains 1 word/cycle when m_ready is held high.
  - It never over-commits the skid buffer.
- Latency:
  - FIFO non-empty -> fifo_remove in the same cycle.
  - Data captured at the next clk_out edge; m_valid=1 the cycle after capture.
  - Minimum FIFO-empty-deassert-to-m_valid latency is 2 cycles.
- Storage: two registers, head and tail.
  - m_data = head.
  - On pop with occ=TWO, tail moves to head.
  - An arriving word writes head if occ after pop is 0, otherwise tail.
- Stream rules:
  - Once m_valid=1, m_data and m_valid hold stable until pop.
  - m_valid depends only on registered state (no combinational path from m_ready to m_valid).
- Flush:
  - In the flush cycle, fifo_remove=0.
  - Next cycle: occ=EMPTY and m_valid=0.
  - Any word still in flight from a remove issued in the flush cycle or earlier is discarded via the drop flag. The drop flag is set when flush && (inflight or remove pending) and clears after one cycle.
  - xfer_count is not cleared by flush.
  - A pop coinciding with flush still counts.
- Counter: xfer_count increments by 1 on each pop and wraps from 2^CNT_W-1 to 0.
- Simultaneous events:
  - flush has priority over arrival.
  - Arrival plus pop in the same cycle is legal in every state.
- Reset mid-transfer: everything returns to reset values immediately. Any in-flight word is lost. Release must be synchronised externally to clk_out.
- fifo_empty is trusted as registered. The block must not issue remove while fifo_empty=1.

Decomposition:
- Shared package:
  - Occupancy state typedef (EMPTY/ONE/TWO) as a 2-bit enumerated constant set.
  - Default WIDTH=32, shared with the FIFO top.
- Natural sub-module: fifo_rd_skid. It holds the 2-entry head/tail storage plus the occupancy FSM, with push/pop in and valid/data out.
- The top keeps the remove rule, in-flight/drop tracking and the counter.

Test Plan:
- Reset, then FIFO holds 0xA1, 0xA2, 0xA3 with m_ready=1 -> m_data 0xA1, 0xA2, 0xA3 on 3 consecutive cycles starting 2 cycles after reset release; xfer_count=3.
- m_ready=0 with FIFO holding 5 words -> exactly 2 removes issued, occ=TWO, m_data=first word held stable; m_ready=1 -> all 5 delivered in order at 1/cycle, no gaps after the first.
- Alternating m_ready (1,0,1,0...) over 8 words 0x10..0x17 -> in-order delivery with no loss or duplication; fifo_remove never high when occ+inflight-pop >= 2.
- flush asserted while occ=TWO and one word in flight -> m_valid=0 next cycle; the in-flight word is never presented; the next remove after flush delivers the following FIFO word.
- fifo_empty=1 throughout -> fifo_remove=0 and m_valid=0 for all cycles.
- Preload xfer_count to 0xFFFE via 2^16-2 transfers (or CNT_W=4 build: 14 transfers), then 3 pops -> count reads 0xFFFF, 0x0000, 0x0001 (CNT_W=4 build: 0xF, 0x0, 0x1); asserting reset mid-stream -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/fifo_rd_stream_pkg.sv
// fifo_rd_stream_pkg: shared occupancy type and default widths for the FIFO read-side drain stage
package fifo_rd_stream_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_CNT_W = 16;
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_t;
endpackage

// File: rtl/fifo_rd_skid.sv
// fifo_rd_skid: 2-entry head/tail skid buffer with occupancy FSM; head is always the oldest word
module fifo_rd_skid
  import fifo_rd_stream_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk_out,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             ready,
  output logic             pop,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output occ_t             occ
);
  occ_t             occ_next;
  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] tail;
  logic             empty_after_pop;
  assign valid           = occ != EMPTY;
  assign pop             = valid && ready;
  assign data            = head;
  assign empty_after_pop = occ == EMPTY || (occ == ONE && pop);
  // occupancy next state: flush empties, arrival and pop together leave it unchanged
  always_comb begin
    occ_next = occ;
    if (flush)
      occ_next = EMPTY;
    else if (push && !pop)
      occ_next = (occ == EMPTY) ? ONE : TWO;
    else if (pop && !push)
      occ_next = (occ == TWO) ? ONE : EMPTY;
  end
  // occupancy state register
  always_ff @(posedge clk_out or negedge reset)
    if (!reset)
      occ <= EMPTY;
    else
      occ <= occ_next;
  // storage: tail shifts into head on pop from TWO; an arrival fills whichever slot is free after the pop
  always_ff @(posedge clk_out or negedge reset)
    if (!reset) begin
      head <= '0;
      tail <= '0;
    end else if (!flush) begin
      if (pop && occ == TWO)
        head <= tail;
      if (push) begin
        if (empty_after_pop)
          head <= din;
        else
          tail <= din;
      end
    end
endmodule

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: drains the async FIFO read port into a valid/ready stream at one word per cycle
module fifo_rd_stream
  import fifo_rd_stream_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk_out,
  input  logic             reset,
  input  logic [WIDTH-1:0] fifo_data,
  input  logic             fifo_empty,
  output logic             fifo_remove,
  input  logic             flush,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [CNT_W-1:0] xfer_count
);
  occ_t       occ;
  logic       inflight;
  logic       drop;
  logic       pop;
  logic       push;
  logic [2:0] committed;
  // words already owned by the buffer after this cycle's pop, counting the one on the FIFO bus
  assign committed   = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
  // gated by reset so no remove leaks out while the block is held in reset
  assign fifo_remove = reset && !fifo_empty && !flush && committed < 3'd2;
  assign push        = inflight && !drop && !flush;
  fifo_rd_skid #(.WIDTH(WIDTH)) u_skid (
    .clk_out (clk_out),
    .reset   (reset),
    .flush   (flush),
    .push    (push),
    .din     (fifo_data),
    .ready   (m_ready),
    .pop     (pop),
    .valid   (m_valid),
    .data    (m_data),
    .occ     (occ)
  );
  // track the word on the FIFO bus next cycle and whether a flush has disowned it
  always_ff @(posedge clk_out or negedge reset)
    if (!reset) begin
      inflight <= 1'b0;
      drop     <= 1'b0;
    end else begin
      inflight <= fifo_remove;
      drop     <= flush && (inflight || fifo_remove);
    end
  // delivered-word counter, untouched by flush, wraps naturally
  always_ff @(posedge clk_out or negedge reset)
    if (!reset)
      xfer_count <= '0;
    else if (pop)
      xfer_count <= xfer_count + CNT_W'(1);
endmodule
